// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame length and the
// parity helper used by both link ends.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  localparam int NUMBER_OF_BITS = 8 + 1 + 2;

  function automatic int number_of_bits(
    input int data_width,
    input int parity_enabled
  );
    return data_width + parity_enabled + 2;
  endfunction

  // Zero-extended data does not change the XOR reduction.
  function automatic logic calc_parity(
    input logic [15:0] data,
    input logic        odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_synchronizer.sv
// Flop chain bringing the asynchronous line into the clk domain;
// resets to the idle (high) level.
module uart_synchronizer #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chain <= '1;
    else          chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with start glitch rejection, parity and
// framing error pulses, and break handling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH           = 8,
  parameter int PARITY_ENABLED             = 1,
  parameter int PARITY_TYPE                = 0,
  parameter int CLOCKS_PER_BIT             = 8,
  parameter int NUMBER_OF_RX_SYNCHRONIZERS = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        serial_in,
  output logic [INPUT_DATA_WIDTH-1:0] received_data,
  output logic                        data_is_valid,
  output logic                        rx_error,
  output logic                        framing_error,
  output logic                        rx_busy
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int BW = $clog2(INPUT_DATA_WIDTH + 1);
  localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST = BW'(INPUT_DATA_WIDTH - 1);

  logic                        rx_s;
  rx_state_t                   state;
  logic [CW-1:0]               clk_cnt;
  logic [BW-1:0]               bit_cnt;
  logic [INPUT_DATA_WIDTH-1:0] shift;
  logic [INPUT_DATA_WIDTH-1:0] shift_nxt;
  logic                        par_err;
  logic                        expired;
  logic                        par_exp;

  uart_synchronizer #(
    .STAGES(NUMBER_OF_RX_SYNCHRONIZERS)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (serial_in),
    .q      (rx_s)
  );

  assign expired   = (clk_cnt == '0);
  assign shift_nxt = INPUT_DATA_WIDTH'({rx_s, shift} >> 1);
  assign par_exp   = calc_parity(16'(shift), 1'(PARITY_TYPE));
  assign rx_busy   = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      par_err       <= 1'b0;
      received_data <= '0;
      data_is_valid <= 1'b0;
      rx_error      <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_is_valid <= 1'b0;
      rx_error      <= 1'b0;
      framing_error <= 1'b0;
      if (!expired) clk_cnt <= clk_cnt - 1'b1;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            clk_cnt <= HALF;
            bit_cnt <= '0;
            par_err <= 1'b0;
            state   <= START_BIT;
          end
        end
        START_BIT: begin
          if (expired) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              clk_cnt <= FULL;
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (expired) begin
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt + 1'b1;
            clk_cnt <= FULL;
            if (bit_cnt == LAST)
              state <= (PARITY_ENABLED != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (expired) begin
            par_err <= (rx_s != par_exp);
            clk_cnt <= FULL;
            state   <= STOP;
          end
        end
        STOP: begin
          if (expired) begin
            if (rx_s) begin
              received_data <= shift;
              data_is_valid <= !par_err;
              rx_error      <= par_err;
              state         <= IDLE;
            end else begin
              framing_error <= 1'b1;
              rx_error      <= par_err;
              state         <= BREAK_WAIT;
            end
          end
        end
        BREAK_WAIT: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
